// File: rtl/biriscv_inst_encoder_pkg.sv
// Shared constants for the instruction encoder: request classes, base opcodes, funct7 values.
// The optional M-extension path is enabled by defining BIRISCV_ENC_MULDIV_EN.
package biriscv_inst_encoder_pkg;

    typedef enum logic [3:0] {
        ENC_ALU_R  = 4'd0,
        ENC_ALU_I  = 4'd1,
        ENC_LUI    = 4'd2,
        ENC_AUIPC  = 4'd3,
        ENC_LOAD   = 4'd4,
        ENC_STORE  = 4'd5,
        ENC_BRANCH = 4'd6,
        ENC_JAL    = 4'd7,
        ENC_JALR   = 4'd8,
        ENC_CSR    = 4'd9,
        ENC_LI     = 4'd10,
        ENC_MULDIV = 4'd11
    } enc_class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // funct7 for R-type and shift-immediates: only bit 5 (SUB/SRA) varies
    function automatic logic [6:0] f7_alt(input logic alt);
        return {1'b0, alt, 5'b00000};
    endfunction

    typedef struct packed {
        logic [3:0]  cls;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_fields_t;

endpackage

// File: rtl/biriscv_inst_format.sv
// Combinational field-to-word packer for RV32I (and M when BIRISCV_ENC_MULDIV_EN is defined).
// LI is not handled here; the top level rewrites it into LUI/ADDI before packing.
module biriscv_inst_format
    import biriscv_inst_encoder_pkg::*;
(
    input  enc_fields_t f_i,
    output logic [31:0] word_o,
    output logic        supported_o
);

    logic [31:0] im;
    assign im = f_i.imm;

    always_comb begin
        word_o      = '0;
        supported_o = 1'b1;
        case (f_i.cls)
            ENC_ALU_R:  word_o = {f7_alt(f_i.alt), f_i.rs2, f_i.rs1, f_i.funct3, f_i.rd, OPC_OP};
            ENC_ALU_I: begin
                // SLLI/SRLI/SRAI carry a shamt plus funct7 instead of a 12-bit immediate
                if (f_i.funct3 == 3'b001 || f_i.funct3 == 3'b101)
                    word_o = {f7_alt(f_i.alt), im[4:0], f_i.rs1, f_i.funct3, f_i.rd, OPC_OP_IMM};
                else
                    word_o = {im[11:0], f_i.rs1, f_i.funct3, f_i.rd, OPC_OP_IMM};
            end
            ENC_LUI:    word_o = {im[31:12], f_i.rd, OPC_LUI};
            ENC_AUIPC:  word_o = {im[31:12], f_i.rd, OPC_AUIPC};
            ENC_LOAD:   word_o = {im[11:0], f_i.rs1, f_i.funct3, f_i.rd, OPC_LOAD};
            ENC_STORE:  word_o = {im[11:5], f_i.rs2, f_i.rs1, f_i.funct3, im[4:0], OPC_STORE};
            ENC_BRANCH: word_o = {im[12], im[10:5], f_i.rs2, f_i.rs1, f_i.funct3,
                                  im[4:1], im[11], OPC_BRANCH};
            ENC_JAL:    word_o = {im[20], im[10:1], im[11], im[19:12], f_i.rd, OPC_JAL};
            ENC_JALR:   word_o = {im[11:0], f_i.rs1, 3'b000, f_i.rd, OPC_JALR};
            ENC_CSR:    word_o = {im[11:0], f_i.rs1, f_i.funct3, f_i.rd, OPC_SYSTEM};
`ifdef BIRISCV_ENC_MULDIV_EN
            ENC_MULDIV: word_o = {F7_MULDIV, f_i.rs2, f_i.rs1, f_i.funct3, f_i.rd, OPC_OP};
`endif
            default:    supported_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/biriscv_inst_encoder.sv
// Instruction encoder top: request handshake, LI split into LUI/ADDI, registered output stage.
// Define BIRISCV_ENC_MULDIV_EN to accept ENC_MULDIV; otherwise it is reported via error_o.
module biriscv_inst_encoder
    import biriscv_inst_encoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_accept_o,
    input  logic [3:0]  req_class_i,
    input  logic [2:0]  req_funct3_i,
    input  logic        req_alt_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        inst_valid_o,
    input  logic        inst_accept_i,
    output logic [31:0] inst_opcode_o,
    output logic        inst_last_o,
    output logic        error_o
);

    typedef enum logic {ST_IDLE, ST_LI_LO} state_e;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] opcode_q, opcode_d;
    logic        last_q, last_d;
    logic        error_q, error_d;
    logic [4:0]  li_rd_q, li_rd_d;
    logic [11:0] li_lo_q, li_lo_d;

    logic        out_free, req_take;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic        is_li, li_two;
    enc_fields_t fmt_in;
    logic [31:0] fmt_word;
    logic        fmt_ok;

    assign out_free     = !valid_q || inst_accept_i;
    assign req_accept_o = rst_ni && (state_q == ST_IDLE) && out_free;
    assign req_take     = req_accept_o && req_valid_i;

    // hi is rounded so that the sign-extended ADDI of lo lands on the exact value
    assign li_hi  = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
    assign li_lo  = req_imm_i[11:0];
    assign is_li  = (req_class_i == ENC_LI);
    assign li_two = is_li && (li_lo != 12'd0) && (li_hi != 20'd0);

    always_comb begin
        fmt_in = '{cls: req_class_i, funct3: req_funct3_i, alt: req_alt_i, rd: req_rd_i,
                   rs1: req_rs1_i, rs2: req_rs2_i, imm: req_imm_i};
        if (state_q == ST_LI_LO) begin
            fmt_in = '{cls: ENC_ALU_I, funct3: 3'b000, alt: 1'b0, rd: li_rd_q,
                       rs1: li_rd_q, rs2: 5'd0, imm: {20'd0, li_lo_q}};
        end else if (is_li) begin
            if (li_lo == 12'd0 || li_two)
                fmt_in = '{cls: ENC_LUI, funct3: 3'b000, alt: 1'b0, rd: req_rd_i,
                           rs1: 5'd0, rs2: 5'd0, imm: {li_hi, 12'd0}};
            else
                fmt_in = '{cls: ENC_ALU_I, funct3: 3'b000, alt: 1'b0, rd: req_rd_i,
                           rs1: 5'd0, rs2: 5'd0, imm: {20'd0, li_lo}};
        end
    end

    biriscv_inst_format u_format (
        .f_i         (fmt_in),
        .word_o      (fmt_word),
        .supported_o (fmt_ok)
    );

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q && !inst_accept_i;
        opcode_d = opcode_q;
        last_d   = last_q;
        error_d  = 1'b0;
        li_rd_d  = li_rd_q;
        li_lo_d  = li_lo_q;
        if (state_q == ST_LI_LO) begin
            if (out_free) begin
                valid_d  = 1'b1;
                opcode_d = fmt_word;
                last_d   = 1'b1;
                state_d  = ST_IDLE;
            end
        end else if (req_take) begin
            if (!fmt_ok) begin
                error_d = 1'b1;
            end else begin
                valid_d  = 1'b1;
                opcode_d = fmt_word;
                last_d   = !li_two;
                if (li_two) begin
                    state_d = ST_LI_LO;
                    li_rd_d = req_rd_i;
                    li_lo_d = li_lo;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
            li_rd_q  <= '0;
            li_lo_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            last_q   <= last_d;
            error_q  <= error_d;
            li_rd_q  <= li_rd_d;
            li_lo_q  <= li_lo_d;
        end
    end

    assign inst_valid_o  = valid_q;
    assign inst_opcode_o = opcode_q;
    assign inst_last_o   = last_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_biriscv_inst_encoder.sv
// Scoreboard bench for biriscv_inst_encoder: directed requests push expected words,
// a monitor pops and compares on every output handshake and tracks error pulses.
module tb_biriscv_inst_encoder;
    import biriscv_inst_encoder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_accept_o;
    logic [3:0]  req_class_i;
    logic [2:0]  req_funct3_i;
    logic        req_alt_i;
    logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
    logic [31:0] req_imm_i;
    logic        inst_valid_o;
    logic        inst_accept_i;
    logic [31:0] inst_opcode_o;
    logic        inst_last_o;
    logic        error_o;

    typedef struct {
        logic [31:0] op;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   exp_err = 0;
    int   checks  = 0;
    int   errors  = 0;

    biriscv_inst_encoder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_accept_o  (req_accept_o),
        .req_class_i   (req_class_i),
        .req_funct3_i  (req_funct3_i),
        .req_alt_i     (req_alt_i),
        .req_rd_i      (req_rd_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_imm_i     (req_imm_i),
        .inst_valid_o  (inst_valid_o),
        .inst_accept_i (inst_accept_i),
        .inst_opcode_o (inst_opcode_o),
        .inst_last_o   (inst_last_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] op, input logic last);
        exp_t e;
        e.op   = op;
        e.last = last;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic issue(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        int n = 0;
        req_class_i  = cls;
        req_funct3_i = f3;
        req_alt_i    = alt;
        req_rd_i     = rd;
        req_rs1_i    = rs1;
        req_rs2_i    = rs2;
        req_imm_i    = imm;
        req_valid_i  = 1'b1;
        while (!req_accept_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout actual=0 expected=1");
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        repeat (2) @(negedge clk_i);
    endtask

    // Monitor: samples 2 time units after each negedge, well away from posedge.
    always begin
        exp_t e;
        @(negedge clk_i);
        #2;
        if (rst_ni === 1'b1) begin
            if (error_o) begin
                checks++;
                if (exp_err == 0) begin
                    errors++;
                    $display("FAIL error_pulse actual=1 expected=0");
                end else begin
                    exp_err--;
                end
            end
            if (inst_valid_o && inst_accept_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h expected=none", inst_opcode_o);
                end else begin
                    e = q.pop_front();
                    if (inst_opcode_o !== e.op || inst_last_o !== e.last) begin
                        errors++;
                        $display("FAIL word actual=%h/%0b expected=%h/%0b",
                                 inst_opcode_o, inst_last_o, e.op, e.last);
                    end
                end
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_class_i   = '0;
        req_funct3_i  = '0;
        req_alt_i     = 1'b0;
        req_rd_i      = '0;
        req_rs1_i     = '0;
        req_rs2_i     = '0;
        req_imm_i     = '0;
        inst_accept_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_valid",      32'(inst_valid_o), 32'd0);
        chk("rst_opcode",     inst_opcode_o,     32'd0);
        chk("rst_last",       32'(inst_last_o),  32'd0);
        chk("rst_error",      32'(error_o),      32'd0);
        chk("rst_req_accept", 32'(req_accept_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // ADDI x1,x0,5 visible the cycle after acceptance
        expect_word(32'h00500093, 1'b1);
        issue(ENC_ALU_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("alui_latency_valid", 32'(inst_valid_o), 32'd1);
        chk("alui_latency_op",    inst_opcode_o,     32'h00500093);

        // Two-word LI on consecutive cycles
        expect_word(32'h123462B7, 1'b0);
        expect_word(32'hFFF28293, 1'b1);
        issue(ENC_LI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        chk("li2_first_last",  32'(inst_last_o), 32'd0);
        @(negedge clk_i);
        chk("li2_second_op",   inst_opcode_o,     32'hFFF28293);
        chk("li2_second_last", 32'(inst_last_o),  32'd1);

        // LI single-word forms: lo==0, hi==0, and the 0xFFFFFFFF wrap
        expect_word(32'h000100B7, 1'b1);
        issue(ENC_LI, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00010000);
        expect_word(32'h7FF00113, 1'b1);
        issue(ENC_LI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h000007FF);
        expect_word(32'hFFF00113, 1'b1);
        issue(ENC_LI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF);

        // Assorted formats back to back
        expect_word(32'h402081B3, 1'b1);
        issue(ENC_ALU_R, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word(32'h40315093, 1'b1);
        issue(ENC_ALU_I, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3);
        expect_word(32'h0020A223, 1'b1);
        issue(ENC_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
        expect_word(32'h008000EF, 1'b1);
        issue(ENC_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        expect_word(32'h300110F3, 1'b1);
        issue(ENC_CSR, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h00000300);
        drain();

        // Backpressure: word holds, no request accepted
        inst_accept_i = 1'b0;
        expect_word(32'h00208463, 1'b1);
        issue(ENC_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_op",         inst_opcode_o,     32'h00208463);
            chk("stall_last",       32'(inst_last_o),  32'd1);
            chk("stall_req_accept", 32'(req_accept_o), 32'd0);
            @(negedge clk_i);
        end
        req_valid_i   = 1'b0;
        inst_accept_i = 1'b1;
        drain();

        // M extension or unsupported path, then a reserved class
`ifdef BIRISCV_ENC_MULDIV_EN
        expect_word(32'h022081B3, 1'b1);
`else
        exp_err++;
`endif
        issue(ENC_MULDIV, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        drain();
        exp_err++;
        issue(4'd15, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        drain();
        chk("error_pulses_seen", 32'(exp_err), 32'd0);

        // Reset between the two LI words drops the pending ADDI
        inst_accept_i = 1'b0;
        issue(ENC_LI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        chk("midli_lui_valid", 32'(inst_valid_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midli_rst_valid",  32'(inst_valid_o), 32'd0);
        chk("midli_rst_opcode", inst_opcode_o,     32'd0);
        inst_accept_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("post_rst_valid", 32'(inst_valid_o), 32'd0);

        expect_word(32'h00500093, 1'b1);
        issue(ENC_ALU_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
